alu_sweep_driver: RTL
=====================

Name: alu_sweep_driver

Overview:
- Hardware stimulus generator and checker: the driving end of the 16-bit ALU interface (operand A, operand B, 4-bit command in; 16-bit result out).
- Sweeps a programmed rectangle of operand pairs, presents one pair per clock, and compares each ALU result against a modulo-2^WIDTH golden sum.
- Used for on-target ALU self-test and as a synthesizable bench driver.
- Overflow is defined as wrap-around: the golden value is (a+b) mod 2^WIDTH.

Parameters:
- WIDTH, 16, operand/result width.
- ADD_CMD, 4'h0, command code for addition.
- SUB_CMD, 4'h1, command code for subtraction (used only with the optional feature).
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- a_start  in  WIDTH  first A value; latched on accepted start.
- a_end  in  WIDTH  last A value, inclusive.
- b_start  in  WIDTH  first B value.
- b_end  in  WIDTH  last B value, inclusive.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_cmd  out  4  registered command to the ALU.
- alu_result  in  WIDTH  combinational ALU result for the current alu_a/alu_b/alu_cmd.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; level signal.
- err_count  out  ERR_W  number of mismatches; saturates at all-ones.
- first_err_a  out  WIDTH  A of the first mismatch.
- first_err_b  out  WIDTH  B of the first mismatch.
- first_err_res  out  WIDTH  ALU result of the first mismatch.
- err_flag  out  1  at least one mismatch seen this sweep.

Behaviour:
- Reset: state IDLE. All outputs 0, except alu_cmd = ADD_CMD. Reset mid-sweep aborts immediately, with no drain.
- States:
  - IDLE: start=1 latches the ranges and clears err_count, err_flag and first_err_*. If a_start>a_end or b_start>b_end, go to DONE. Otherwise go to RUN with alu_a=a_start, alu_b=b_start.
  - RUN: each cycle the check stage compares the pair currently presented. Order: B inner loop, A outer loop. When alu_b==b_end, B reloads b_start and A increments. When alu_a==a_end and alu_b==b_end, this is the last pair; go to DONE after checking it.
  - DONE: done=1, busy=0, outputs hold. start=1 behaves as in IDLE.
- busy = 1 exactly while in RUN. start is ignored while busy.
- Checking:
  - Expected = (alu_a + alu_b) truncated to WIDTH.
  - Compare against alu_result in the same cycle.
  - On mismatch, err_count increments at the clock edge (saturating), and err_flag is set.
  - first_err_* capture only on the first mismatch of a sweep.
- Counters use WIDTH+1-bit compare internally. A range ending at all-ones terminates without wrapping to 0, and the sweep is never infinite.
- Latency: for N = (a_end-a_start+1)*(b_end-b_start+1) pairs, with start sampled at edge E0:
  - pair k is presented after edge E_k;
  - done=1 after edge E_N;
  - err_count is final at done.
  - Empty range: done=1 after E1.
- alu_cmd = ADD_CMD throughout (without the optional feature).

Optional Feature:
- Macro: ALU_SWEEP_SUB_EN.
- Defined:
  - Each pair is presented twice on consecutive cycles: first with alu_cmd=ADD_CMD (expected a+b), then with SUB_CMD (expected (a-b) mod 2^WIDTH).
  - Done occurs after 2N edges.
  - first_err_* captures the first failing operation of either kind.
  - An extra output first_err_sub (1 bit) marks a subtraction failure.
- Undefined: add only. first_err_sub does not exist. SUB_CMD is unused.

Test Plan:
- Reset: assert rst 2 cycles -> alu_a=alu_b=0, alu_cmd=4'h0, busy=done=err_flag=0, err_count=0.
- Sweep a=0..3, b=0..3, correct ALU model:
  - pairs appear in order (0,0),(0,1),(0,2),(0,3),(1,0)..(3,3), one per cycle;
  - busy for 16 cycles; done after E16; err_count=0.
- Overflow wrap, a=FFFF..FFFF, b=0000..0001:
  - correct model -> err_count=0;
  - model saturating to FFFF -> err_count=1, first_err=(FFFF,0001,FFFF).
- Fault injection, result bit0 stuck-at-0, a=0..1, b=0..1 -> err_count=2, first_err=(0000,0001,0000), err_flag=1.
- Empty range, a_start=5, a_end=4 -> busy never high, done=1 one cycle after start, err_count=0. A second start in DONE with a valid range runs normally.
- Reset mid-sweep: start a 0..FF x 0..FF sweep, assert rst at cycle 10 -> next edge IDLE, all outputs at reset values. A subsequent 0..1 x 0..1 sweep completes with done after 4 cycles.

Source files
------------

// File: rtl/alu_sweep_driver_if.sv
// ALU operand/command/result bus between a sweep driver and an ALU.
// The driver is the master; the ALU answers combinationally.
interface alu_sweep_driver_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_cmd;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output alu_a,
    output alu_b,
    output alu_cmd,
    input  alu_result
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_cmd,
    output alu_result
  );
endinterface

// File: rtl/alu_sweep_driver.sv
// ALU sweep driver: walks an A x B rectangle and checks each result.
// Define ALU_SWEEP_SUB_EN to also test subtraction on every pair.
module alu_sweep_driver #(
  parameter int         WIDTH   = 16,
  parameter logic [3:0] ADD_CMD = 4'h0,
  parameter logic [3:0] SUB_CMD = 4'h1,
  parameter int         ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_start,
  input  logic [WIDTH-1:0] a_end,
  input  logic [WIDTH-1:0] b_start,
  input  logic [WIDTH-1:0] b_end,
  alu_sweep_driver_if.master alu,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] first_err_res,
`ifdef ALU_SWEEP_SUB_EN
  output logic             first_err_sub,
`endif
  output logic             err_flag
);

  typedef enum logic [1:0] {
    IDLE,
    EMPTY,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_hi;
  logic [WIDTH-1:0] b_lo;
  logic [WIDTH-1:0] b_hi;
  logic [WIDTH-1:0] expect_res;
  logic             accept;
  logic             empty;
  logic             a_last;
  logic             b_last;
  logic             pair_end;
  logic             mismatch;

  assign accept = start &&
                  (state == IDLE || state == DONE);
  assign empty  = (a_start > a_end) ||
                  (b_start > b_end);

  // One spare bit keeps an all-ones end from wrapping.
  assign a_last = {1'b0, alu.alu_a} >= {1'b0, a_hi};
  assign b_last = {1'b0, alu.alu_b} >= {1'b0, b_hi};

`ifdef ALU_SWEEP_SUB_EN
  logic sub_ph;
  assign pair_end = sub_ph;
`else
  assign pair_end = 1'b1;
`endif

  always_comb begin
    expect_res = alu.alu_a + alu.alu_b;
    if (alu.alu_cmd == SUB_CMD)
      expect_res = alu.alu_a - alu.alu_b;
  end

  assign mismatch = (state == RUN) &&
                    (alu.alu_result != expect_res);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE:
        if (start) state_nxt = empty ? EMPTY : RUN;
      EMPTY:
        state_nxt = DONE;
      RUN:
        if (pair_end && a_last && b_last)
          state_nxt = DONE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu.alu_a     <= '0;
      alu.alu_b     <= '0;
      alu.alu_cmd   <= ADD_CMD;
      a_hi          <= '0;
      b_lo          <= '0;
      b_hi          <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_res <= '0;
`ifdef ALU_SWEEP_SUB_EN
      first_err_sub <= 1'b0;
      sub_ph        <= 1'b0;
`endif
    end else if (accept) begin
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_res <= '0;
`ifdef ALU_SWEEP_SUB_EN
      first_err_sub <= 1'b0;
      sub_ph        <= 1'b0;
      alu.alu_cmd   <= ADD_CMD;
`endif
      if (!empty) begin
        alu.alu_a <= a_start;
        alu.alu_b <= b_start;
        a_hi      <= a_end;
        b_lo      <= b_start;
        b_hi      <= b_end;
      end
    end else if (state == RUN) begin
      if (mismatch) begin
        if (err_count != {ERR_W{1'b1}})
          err_count <= err_count + 1'b1;
        err_flag <= 1'b1;
        if (!err_flag) begin
          first_err_a   <= alu.alu_a;
          first_err_b   <= alu.alu_b;
          first_err_res <= alu.alu_result;
`ifdef ALU_SWEEP_SUB_EN
          first_err_sub <= (alu.alu_cmd == SUB_CMD);
`endif
        end
      end
`ifdef ALU_SWEEP_SUB_EN
      sub_ph      <= !sub_ph;
      alu.alu_cmd <= sub_ph ? ADD_CMD : SUB_CMD;
`endif
      // Last pair holds its operands so DONE keeps them visible.
      if (pair_end) begin
        if (!b_last) begin
          alu.alu_b <= alu.alu_b + 1'b1;
        end else if (!a_last) begin
          alu.alu_b <= b_lo;
          alu.alu_a <= alu.alu_a + 1'b1;
        end
      end
    end
  end

endmodule
